// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: per-program start table, absolute and
// relative branches, call/return through a small return-address stack, stall and halt.
module pc_sequencer #(
  parameter int                         PC_W      = 10,
  parameter int                         NUM_PROGS = 3,
  parameter logic [NUM_PROGS*PC_W-1:0]  PROG_BASE = '0,
  parameter int                         RAS_DEPTH = 4,
  localparam int SEL_W   = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
  localparam int DEPTH_W = $clog2(RAS_DEPTH + 1),
  localparam int PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [SEL_W-1:0] ProgSel,
  input  logic             Stall,
  input  logic             Jump,
  input  logic             Call,
  input  logic             Ret,
  input  logic             BranchAbsOrRel,
  input  logic             Halt,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             Fault
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

  localparam logic [SEL_W:0]   NUM_PROGS_W = (SEL_W + 1)'(NUM_PROGS);
  localparam logic [DEPTH_W-1:0] RAS_DEPTH_W = DEPTH_W'(RAS_DEPTH);

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                fault_q, fault_d;
  logic [PC_W-1:0]     ras_q [RAS_DEPTH];

  logic                sel_ok;
  logic [PC_W-1:0]     base_sel;
  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     branch_pc;
  logic [PTR_W-1:0]    top_ptr;
  logic                push;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    base_sel = PROG_BASE[0 +: PC_W];
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (ProgSel == SEL_W'(i)) base_sel = PROG_BASE[i*PC_W +: PC_W];
    end
  end

  assign sel_ok    = ({1'b0, ProgSel} < NUM_PROGS_W);
  assign pc_inc    = pc_q + PC_W'(1);
  // Same-width addition is already the sign-extended, modulo-2^PC_W relative branch.
  assign branch_pc = BranchAbsOrRel ? (pc_q + Target) : Target;
  assign top_ptr   = depth_q[PTR_W-1:0] - PTR_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    fault_d = fault_q;
    push    = 1'b0;

    if (Start) begin
      if (sel_ok) begin
        state_d = S_ARMED;
        pc_d    = base_sel;
        depth_d = '0;
        fault_d = 1'b0;
      end else begin
        fault_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        S_ARMED: state_d = S_RUN;
        S_RUN: begin
          if (Stall) begin
            pc_d = pc_q;
          end else if (Halt) begin
            state_d = S_DONE;
          end else if (Ret) begin
            if (depth_q != '0) begin
              pc_d    = ras_q[top_ptr];
              depth_d = depth_q - DEPTH_W'(1);
            end else begin
              fault_d = 1'b1;
              pc_d    = pc_inc;
            end
          end else if (Call) begin
            if (depth_q != RAS_DEPTH_W) begin
              push    = 1'b1;
              pc_d    = branch_pc;
              depth_d = depth_q + DEPTH_W'(1);
            end else begin
              fault_d = 1'b1;
              pc_d    = pc_inc;
            end
          end else if (Jump) begin
            pc_d = branch_pc;
          end else begin
            pc_d = pc_inc;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= PROG_BASE[0 +: PC_W];
      depth_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
    end
  end

  // NOTE: stack storage is not reset; depth_q alone decides which entries are valid.
  always_ff @(posedge Clk) begin
    if (Reset && push) ras_q[depth_q[PTR_W-1:0]] <= pc_inc;
  end

  assign ProgCtr  = pc_q;
  assign Running  = (state_q == S_RUN);
  assign Done     = (state_q == S_DONE);
  assign RasEmpty = (depth_q == '0);
  assign RasFull  = (depth_q == RAS_DEPTH_W);
  assign Fault    = fault_q;

endmodule
